// File: rtl/lsu_mem_port.sv
// Load/store unit port: accepts one CPU request at a time and drives a zero-latency
// word RAM, doing read-modify-write for sub-word stores and lane extraction for loads.
module lsu_mem_port #(
  parameter int MEM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic                  ram_we,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RSP = 2'd3} state_t;

  state_t                  state_r, state_nxt_s;
  logic                    accept_s, req_err_s;
  logic                    we_r, we_nxt_s, unsigned_r, unsigned_nxt_s;
  logic [1:0]              size_r, size_nxt_s, off_r, off_nxt_s;
  logic [31:0]             wdata_r, wdata_nxt_s;
  logic [ADDR_WIDTH-1:0]   ram_addr_r, ram_addr_nxt_s;
  logic [31:0]             ram_din_r, ram_din_nxt_s, rsp_rdata_r, rsp_rdata_nxt_s;
  logic                    ram_we_r, ram_we_nxt_s, rsp_valid_r, rsp_valid_nxt_s;
  logic                    rsp_err_r, rsp_err_nxt_s;

  function automatic logic [31:0] merge_lanes(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   res[7:0]   = wdata[7:0];
          2'b01:   res[15:8]  = wdata[7:0];
          2'b10:   res[23:16] = wdata[7:0];
          2'b11:   res[31:24] = wdata[7:0];
          default: res        = word;
        endcase
      end
      2'b01: begin
        if (off[1]) res[31:16] = wdata[15:0];
        else        res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign req_ready = (state_r == IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;

  // Request rejection: illegal size, misalignment, or word index beyond the RAM
  always_comb begin
    req_err_s = 1'b0;
    if (req_size == 2'b11) begin
      req_err_s = 1'b1;
    end else if ((req_size == 2'b01) && req_addr[0]) begin
      req_err_s = 1'b1;
    end else if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) begin
      req_err_s = 1'b1;
    end else if ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH)) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = req_err_s ? RSP : RD;
        else          state_nxt_s = IDLE;
      end
      RD:      state_nxt_s = we_r ? WR : RSP;
      WR:      state_nxt_s = RSP;
      RSP: begin
        if (rsp_ready) state_nxt_s = IDLE;
        else           state_nxt_s = RSP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output and datapath next values; outputs are registered so they follow state by construction
  always_comb begin
    we_nxt_s        = we_r;
    unsigned_nxt_s  = unsigned_r;
    size_nxt_s      = size_r;
    off_nxt_s       = off_r;
    wdata_nxt_s     = wdata_r;
    ram_addr_nxt_s  = ram_addr_r;
    ram_din_nxt_s   = ram_din_r;
    rsp_rdata_nxt_s = rsp_rdata_r;
    rsp_err_nxt_s   = rsp_err_r;
    ram_we_nxt_s    = (state_nxt_s == WR);
    rsp_valid_nxt_s = (state_nxt_s == RSP);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          we_nxt_s        = req_we;
          unsigned_nxt_s  = req_unsigned;
          size_nxt_s      = req_size;
          off_nxt_s       = req_addr[1:0];
          wdata_nxt_s     = req_wdata;
          ram_addr_nxt_s  = req_addr[ADDR_WIDTH+1:2];
          rsp_rdata_nxt_s = 32'h0000_0000;
          rsp_err_nxt_s   = req_err_s;
        end else begin
          rsp_err_nxt_s   = rsp_err_r;
        end
      end
      RD: begin
        ram_din_nxt_s   = merge_lanes(ram_dout, wdata_r, size_r, off_r);
        rsp_rdata_nxt_s = we_r ? 32'h0000_0000 : load_extend(ram_dout, size_r, off_r, unsigned_r);
        rsp_err_nxt_s   = 1'b0;
      end
      WR:      rsp_err_nxt_s = rsp_err_r;
      RSP:     rsp_err_nxt_s = rsp_err_r;
      default: rsp_err_nxt_s = rsp_err_r;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r        <= 1'b0;
      unsigned_r  <= 1'b0;
      size_r      <= 2'b00;
      off_r       <= 2'b00;
      wdata_r     <= 32'h0000_0000;
      ram_addr_r  <= '0;
      ram_din_r   <= 32'h0000_0000;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      ram_we_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      we_r        <= we_nxt_s;
      unsigned_r  <= unsigned_nxt_s;
      size_r      <= size_nxt_s;
      off_r       <= off_nxt_s;
      wdata_r     <= wdata_nxt_s;
      ram_addr_r  <= ram_addr_nxt_s;
      ram_din_r   <= ram_din_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      ram_we_r    <= ram_we_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
    end
  end

  assign ram_addr  = ram_addr_r;
  assign ram_din   = ram_din_r;
  // Gate with rst so a reset landing in WR cannot complete the write
  assign ram_we    = ram_we_r && !rst;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: the driver queues expected responses and RAM
// writes, an independent negedge monitor pops and compares them.
module tb_lsu_mem_port;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [11:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_we;

  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:4095];

  logic [31:0] cyc = 32'd0;
  int          n_cmp = 0;
  int          n_fail = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] rise;
  } rsp_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] din;
    logic [31:0] at;
  } wr_t;

  rsp_t sb[$];
  wr_t  wr_q[$];

  lsu_mem_port #(.MEM_DEPTH(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  assign ram_dout = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: response and RAM-write scoreboards
  logic        prev_valid = 1'b0;
  logic [31:0] rise_cyc = 32'd0;
  always @(negedge clk) begin : monitor
    rsp_t e;
    wr_t  w;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) rise_cyc = cyc + 32'd1;
      prev_valid = rsp_valid;
    end
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", rise_cyc, e.rise);
      end
    end
    if (ram_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_ram_we", 32'(ram_we), 32'h0);
      end else begin
        w = wr_q.pop_front();
        chk("ram_addr", 32'(ram_addr), 32'(w.addr));
        chk("ram_din", ram_din, w.din);
        chk("ram_we_cycle", cyc + 32'd1, w.at);
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic [31:0] exp_din, input bit push);
    rsp_t        r;
    wr_t         w;
    int          n;
    logic [31:0] t;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'h1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(posedge clk); #1;
    t = cyc;
    req_valid = 1'b0;
    if (push) begin
      r.rdata = exp_rdata;
      r.err   = exp_err;
      r.rise  = t + (exp_err ? 32'd1 : (we ? 32'd3 : 32'd2));
      sb.push_back(r);
      if (we && !exp_err) begin
        w.addr = addr[13:2];
        w.din  = exp_din;
        w.at   = t + 32'd2;
        wr_q.push_back(w);
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && wr_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_rsp", 32'(sb.size()), 32'h0);
    chk("drain_wr", 32'(wr_q.size()), 32'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b1;
    pre_we = 1'b0; pre_addr = 12'h000; pre_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'h1);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("idle_rsp_err", 32'(rsp_err), 32'h0);
    chk("idle_rsp_rdata", rsp_rdata, 32'h0);
    chk("idle_ram_addr", 32'(ram_addr), 32'h0);
    chk("idle_ram_din", ram_din, 32'h0);

    // word store then load
    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    wait_done();
    chk("mem4_word", mem[4], 32'hDEADBEEF);
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
    wait_done();

    // byte merge and byte loads
    preload(12'd4, 32'h11223344);
    issue(1'b1, 32'h12, 2'b00, 1'b0, 32'h555555AB, 32'h0, 1'b0, 32'h11AB3344, 1'b1);
    wait_done();
    chk("mem4_byte", mem[4], 32'h11AB3344);
    issue(1'b0, 32'h12, 2'b00, 1'b0, 32'h0, 32'hFFFFFFAB, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h12, 2'b00, 1'b1, 32'h0, 32'h000000AB, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 32'h00000011, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 32'h00000044, 1'b0, 32'h0, 1'b1);
    wait_done();

    // halfword loads and store
    preload(12'd4, 32'h80017FFE);
    issue(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 32'h00007FFE, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 32'h12, 2'b01, 1'b0, 32'h1234CAFE, 32'h0, 1'b0, 32'hCAFE7FFE, 1'b1);
    wait_done();
    chk("mem4_half", mem[4], 32'hCAFE7FFE);

    // rejected requests: no RAM write may appear
    issue(1'b0, 32'h13, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h11, 2'b01, 1'b0, 32'h0000FFFF, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h4000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h4001, 2'b00, 1'b0, 32'h77, 32'h0, 1'b1, 32'h0, 1'b1);
    wait_done();
    chk("mem4_after_err", mem[4], 32'hCAFE7FFE);

    // last in-range word
    preload(12'd4095, 32'h5A5A0001);
    issue(1'b0, 32'h3FFC, 2'b10, 1'b0, 32'h0, 32'h5A5A0001, 1'b0, 32'h0, 1'b1);
    wait_done();

    // backpressure on a load response
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h3FFC, 2'b10, 1'b0, 32'h0, 32'h5A5A0001, 1'b0, 32'h0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(rsp_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rdata", rsp_rdata, 32'h5A5A0001);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_req_ready_hs", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("bp_resume", 32'(req_ready), 32'h1);
    chk("bp_valid_drop", 32'(rsp_valid), 32'h0);
    wait_done();

    // reset while the store sits in WR
    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'h99999999, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("wr_rst_ram_we", 32'(ram_we), 32'h0);
    chk("wr_rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'h1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_rst_mem4", mem[4], 32'hCAFE7FFE);
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hCAFE7FFE, 1'b0, 32'h0, 1'b1);
    wait_done();

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'h0);
    chk("final_wr_empty", 32'(wr_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
